// File: rtl/axi_lite_proc_regs_pkg.sv
// axi_lite_proc_pkg: register indices, processing modes and response codes
package axi_lite_proc_pkg;
    localparam int REG_CTRL  = 0;
    localparam int REG_KEY   = 1;
    localparam int REG_DIN   = 2;
    localparam int REG_DOUT  = 3;
    localparam int REG_COUNT = 4;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_INV  = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_ADD  = 2'b11
    } mode_e;
endpackage

// File: rtl/axi_lite_proc_regs_if.sv
// axi_lite_proc_regs_if: AXI4-Lite bus bundle with master/slave views
interface axi_lite_proc_regs_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic                    RVALID;
    logic                    RREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_proc_regs_alu.sv
// axi_lite_proc_alu: combinational pass/invert/xor/add of an operand with a key
module axi_lite_proc_alu
    import axi_lite_proc_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  mode_e                 mode,
    input  logic [DATA_WIDTH-1:0] op,
    input  logic [DATA_WIDTH-1:0] key,
    output logic [DATA_WIDTH-1:0] result
);
    // select the transform; addition wraps modulo 2**DATA_WIDTH
    always_comb begin
        result = mode == MODE_PASS ? op :
                 mode == MODE_INV  ? ~op :
                 mode == MODE_XOR  ? op ^ key : op + key;
    end
endmodule

// File: rtl/axi_lite_proc_regs.sv
// axi_lite_proc_regs: AXI4-Lite register file feeding a one-word processing unit
module axi_lite_proc_regs
    import axi_lite_proc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 6
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    axi_lite_proc_regs_if.slave bus,
    output logic                proc_done
);
    localparam int SW = DATA_WIDTH / 8;
    typedef logic [DATA_WIDTH-1:0] word_t;
    word_t                 regs_q [NUM_REGS];
    word_t                 regs_d [NUM_REGS];
    logic                  aw_rdy_q, aw_rdy_d, w_rdy_q, w_rdy_d, b_valid_q, b_valid_d;
    logic [1:0]            b_resp_q, b_resp_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    word_t                 w_data_q, w_data_d;
    logic [SW-1:0]         w_strb_q, w_strb_d;
    logic                  r_valid_q, r_valid_d;
    word_t                 r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic                  proc_go_q, proc_go_d, proc_done_q, proc_done_d;
    word_t                 op_q, op_d, key_q, key_d;
    mode_e                 mode_q, mode_d;
    word_t                 merged, alu_res;
    logic                  commit, wr_err, b_hs, ar_hs, rd_ok;

    axi_lite_proc_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .mode   (mode_q),
        .op     (op_q),
        .key    (key_q),
        .result (alu_res)
    );

    assign bus.AWREADY = aw_rdy_q;
    assign bus.WREADY  = w_rdy_q;
    assign bus.BVALID  = b_valid_q;
    assign bus.BRESP   = b_resp_q;
    assign bus.ARREADY = !r_valid_q;
    assign bus.RVALID  = r_valid_q;
    assign bus.RDATA   = r_data_q;
    assign bus.RRESP   = r_resp_q;
    assign proc_done   = proc_done_q;

    // write channel: hold AW and W until both are present, commit once, then respond on B
    always_comb begin
        b_hs      = b_valid_q && bus.BREADY;
        commit    = !aw_rdy_q && !w_rdy_q && !b_valid_q;
        wr_err    = int'(aw_addr_q) >= NUM_REGS || int'(aw_addr_q) == REG_DOUT
                    || int'(aw_addr_q) == REG_COUNT;
        merged    = wr_err ? '0 : regs_q[aw_addr_q];
        for (int i = 0; i < SW; i++)
            if (w_strb_q[i]) merged[i*8 +: 8] = w_data_q[i*8 +: 8];
        aw_rdy_d  = b_hs ? 1'b1 : (bus.AWVALID && aw_rdy_q) ? 1'b0 : aw_rdy_q;
        w_rdy_d   = b_hs ? 1'b1 : (bus.WVALID && w_rdy_q) ? 1'b0 : w_rdy_q;
        aw_addr_d = (bus.AWVALID && aw_rdy_q) ? bus.AWADDR : aw_addr_q;
        w_data_d  = (bus.WVALID && w_rdy_q) ? bus.WDATA : w_data_q;
        w_strb_d  = (bus.WVALID && w_rdy_q) ? bus.WSTRB : w_strb_q;
        b_valid_d = commit ? 1'b1 : b_hs ? 1'b0 : b_valid_q;
        b_resp_d  = commit ? (wr_err ? RESP_SLVERR : RESP_OKAY) : b_resp_q;
    end

    // processing: operand, mode and key are frozen at the DIN commit; DOUT and COUNT follow a cycle later
    always_comb begin
        proc_go_d   = commit && !wr_err && int'(aw_addr_q) == REG_DIN && |w_strb_q;
        proc_done_d = proc_go_q;
        op_d        = proc_go_d ? merged : op_q;
        key_d       = proc_go_d ? regs_q[REG_KEY] : key_q;
        mode_d      = proc_go_d ? mode_e'(regs_q[REG_CTRL][1:0]) : mode_q;
        regs_d      = regs_q;
        if (commit && !wr_err) regs_d[aw_addr_q] = merged;
        if (proc_go_q) begin
            regs_d[REG_DOUT]  = alu_res;
            regs_d[REG_COUNT] = regs_q[REG_COUNT] + word_t'(1);
        end
    end

    // read channel: one outstanding read, data captured from the pre-commit register state
    always_comb begin
        ar_hs     = bus.ARVALID && !r_valid_q;
        rd_ok     = int'(bus.ARADDR) < NUM_REGS;
        r_valid_d = ar_hs ? 1'b1 : bus.RREADY ? 1'b0 : r_valid_q;
        r_data_d  = ar_hs ? (rd_ok ? regs_q[bus.ARADDR] : '0) : r_data_q;
        r_resp_d  = ar_hs ? (rd_ok ? RESP_OKAY : RESP_SLVERR) : r_resp_q;
    end

    // state registers; reset drops any transaction in flight
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs_q      <= '{default: '0};
            aw_rdy_q    <= 1'b1;
            w_rdy_q     <= 1'b1;
            b_valid_q   <= 1'b0;
            b_resp_q    <= RESP_OKAY;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_resp_q    <= RESP_OKAY;
            proc_go_q   <= 1'b0;
            proc_done_q <= 1'b0;
            op_q        <= '0;
            key_q       <= '0;
            mode_q      <= MODE_PASS;
        end else begin
            regs_q      <= regs_d;
            aw_rdy_q    <= aw_rdy_d;
            w_rdy_q     <= w_rdy_d;
            b_valid_q   <= b_valid_d;
            b_resp_q    <= b_resp_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            r_resp_q    <= r_resp_d;
            proc_go_q   <= proc_go_d;
            proc_done_q <= proc_done_d;
            op_q        <= op_d;
            key_q       <= key_d;
            mode_q      <= mode_d;
        end
    end
endmodule
